register_file: RTL and testbench

Parametrised register bank for the processor datapath, succeeding the single 8-bit enable-gated register.
- Storage: DEPTH words of WIDTH bits.
- Ports: one write port with per-byte lane enables, and two independent registered read ports.
- Forwarding: the read ports forward same-cycle writes.
- Optional hardwired zero at address 0.
- Used by the decode stage to supply both ALU operands.

---
 rtl/register_file.sv | 101 ++++++++++
 tb/tb_register_file.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register bank with one byte-masked write port
// and two independent registered read ports. A read of the address being
// written in the same cycle returns the post-write value. When ZERO_REG=1,
// address 0 is hardwired to zero.
module register_file #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int LANES    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [LANES-1:0] wmask,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] in,
  input  logic             ren_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] out_a,
  input  logic             ren_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] out_b
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] merged_next;
  logic [WIDTH-1:0] read_a_next;
  logic [WIDTH-1:0] read_b_next;
  logic [WIDTH-1:0] out_a_reg;
  logic [WIDTH-1:0] out_b_reg;
  logic             waddr_zero;
  logic             write_ok;

  // Address 0 swallows writes only when it is the hardwired zero register.
  assign waddr_zero = (ZERO_REG != 0) && (waddr == '0);
  assign write_ok   = wen && !waddr_zero;

  // Post-write word at waddr: enabled lanes from in, others from storage.
  // The same word feeds both the storage update and the forwarding path,
  // so a forwarded read always matches a later read of that address.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged_next[8*gi +: 8] = wmask[gi] ? in[8*gi +: 8]
                                                : mem_reg[waddr][8*gi +: 8];
    end
  endgenerate

  // Storage update: reset clears every word, otherwise merge the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (write_ok) begin
      mem_reg[waddr] <= merged_next;
    end
  end

  // Port A read value: storage, forwarded write, then the zero override.
  always_comb begin
    read_a_next = mem_reg[raddr_a];
    if (wen && (raddr_a == waddr)) begin
      read_a_next = merged_next;
    end
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      read_a_next = '0;
    end
  end

  // Port B read value: same priority as port A.
  always_comb begin
    read_b_next = mem_reg[raddr_b];
    if (wen && (raddr_b == waddr)) begin
      read_b_next = merged_next;
    end
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      read_b_next = '0;
    end
  end

  // Output registers: cleared by reset, loaded on enable, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a_reg <= '0;
      out_b_reg <= '0;
    end else begin
      if (ren_a) begin
        out_a_reg <= read_a_next;
      end
      if (ren_b) begin
        out_b_reg <= read_b_next;
      end
    end
  end

  assign out_a = out_a_reg;
  assign out_b = out_b_reg;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks on three register_file instances:
// 8-bit with zero register, 8-bit without it, and 32-bit with it.
module tb_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared reset plus the 8-bit stimulus (drives both 8-bit instances).
  logic       rst;
  logic       wen8;
  logic [0:0] wmask8;
  logic [3:0] waddr8;
  logic [7:0] in8;
  logic       ren_a8, ren_b8;
  logic [3:0] raddr_a8, raddr_b8;
  logic [7:0] out_a8, out_b8, out_a8n, out_b8n;

  // 32-bit stimulus.
  logic        wen32;
  logic [3:0]  wmask32;
  logic [3:0]  waddr32;
  logic [31:0] in32;
  logic        ren_a32, ren_b32;
  logic [3:0]  raddr_a32, raddr_b32;
  logic [31:0] out_a32, out_b32;

  register_file #(.WIDTH(8), .DEPTH(16), .ZERO_REG(1)) dut8 (
    .clk(clk), .rst(rst), .wen(wen8), .wmask(wmask8), .waddr(waddr8), .in(in8),
    .ren_a(ren_a8), .raddr_a(raddr_a8), .out_a(out_a8),
    .ren_b(ren_b8), .raddr_b(raddr_b8), .out_b(out_b8)
  );

  register_file #(.WIDTH(8), .DEPTH(16), .ZERO_REG(0)) dut8n (
    .clk(clk), .rst(rst), .wen(wen8), .wmask(wmask8), .waddr(waddr8), .in(in8),
    .ren_a(ren_a8), .raddr_a(raddr_a8), .out_a(out_a8n),
    .ren_b(ren_b8), .raddr_b(raddr_b8), .out_b(out_b8n)
  );

  register_file #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1)) dut32 (
    .clk(clk), .rst(rst), .wen(wen32), .wmask(wmask32), .waddr(waddr32), .in(in32),
    .ren_a(ren_a32), .raddr_a(raddr_a32), .out_a(out_a32),
    .ren_b(ren_b32), .raddr_b(raddr_b32), .out_b(out_b32)
  );

  // Advance past one rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("check %-22s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    wen8 = 0; wmask8 = 0; waddr8 = 0; in8 = 0;
    ren_a8 = 0; ren_b8 = 0; raddr_a8 = 0; raddr_b8 = 0;
    wen32 = 0; wmask32 = 0; waddr32 = 0; in32 = 0;
    ren_a32 = 0; ren_b32 = 0; raddr_a32 = 0; raddr_b32 = 0;
    tick();
    rst = 1'b0;
    chk("reset_out_a8", {24'h0, out_a8}, 32'h0);
    chk("reset_out_b32", out_b32, 32'h0);

    // 1. Read after reset on both ports.
    ren_a8 = 1; raddr_a8 = 4'd1; ren_b8 = 1; raddr_b8 = 4'd15;
    tick();
    chk("rd_after_rst_a", {24'h0, out_a8}, 32'h0);
    chk("rd_after_rst_b", {24'h0, out_b8}, 32'h0);
    ren_a8 = 0; ren_b8 = 0;

    // 2. Write, ignored write (wen=0), readback, then hold.
    wen8 = 1; wmask8 = 1'b1; waddr8 = 4'd3; in8 = 8'h5C;
    tick();
    wen8 = 0; in8 = 8'h0A; ren_a8 = 1; raddr_a8 = 4'd3;
    tick();
    chk("readback_5c", {24'h0, out_a8}, 32'h5C);
    ren_a8 = 0; raddr_a8 = 4'd4; in8 = 8'h77;
    tick();
    chk("hold_5c", {24'h0, out_a8}, 32'h5C);
    // Masked-off write is a no-op.
    wen8 = 1; wmask8 = 1'b0; waddr8 = 4'd3; in8 = 8'hFF;
    tick();
    wen8 = 0; ren_a8 = 1; raddr_a8 = 4'd3;
    tick();
    chk("mask0_noop", {24'h0, out_a8}, 32'h5C);

    // 8-bit forwarding, both ports reading the written address.
    wen8 = 1; wmask8 = 1'b1; waddr8 = 4'd9; in8 = 8'h3C;
    ren_a8 = 1; raddr_a8 = 4'd9; ren_b8 = 1; raddr_b8 = 4'd9;
    tick();
    chk("fwd8_a", {24'h0, out_a8}, 32'h3C);
    chk("fwd8_b", {24'h0, out_b8}, 32'h3C);
    wen8 = 0; ren_a8 = 0; ren_b8 = 0;

    // 5. Zero register: write addr 0 while reading it on B.
    wen8 = 1; wmask8 = 1'b1; waddr8 = 4'd0; in8 = 8'hFF; ren_b8 = 1; raddr_b8 = 4'd0;
    tick();
    chk("zero_fwd_b", {24'h0, out_b8}, 32'h0);
    chk("nozero_fwd_b", {24'h0, out_b8n}, 32'hFF);
    wen8 = 0; in8 = 8'h00;
    tick();
    chk("zero_later_b", {24'h0, out_b8}, 32'h0);
    chk("nozero_later_b", {24'h0, out_b8n}, 32'hFF);
    ren_b8 = 0;

    // 3. Byte lanes at WIDTH=32.
    wen32 = 1; wmask32 = 4'b1111; waddr32 = 4'd2; in32 = 32'hAABBCCDD;
    tick();
    wmask32 = 4'b0101; in32 = 32'h11223344;
    tick();
    wen32 = 0; ren_a32 = 1; raddr_a32 = 4'd2;
    tick();
    chk("lanes_merge", out_a32, 32'hAA22CC44);
    ren_a32 = 0;

    // 4. Forwarding with partial mask onto a zero word.
    wen32 = 1; wmask32 = 4'b0011; waddr32 = 4'd5; in32 = 32'hFFFFFFFF;
    ren_a32 = 1; raddr_a32 = 4'd5;
    tick();
    chk("fwd32_partial", out_a32, 32'h0000FFFF);
    wen32 = 0; ren_a32 = 0; ren_b32 = 1; raddr_b32 = 4'd5;
    tick();
    chk("fwd32_matches_mem", out_b32, 32'h0000FFFF);
    // Forwarding onto a non-zero word keeps the old unmasked lanes.
    wen32 = 1; wmask32 = 4'b1000; waddr32 = 4'd2; in32 = 32'h55000000;
    raddr_b32 = 4'd2;
    tick();
    chk("fwd32_old_lanes", out_b32, 32'h5522CC44);
    wen32 = 0; ren_b32 = 0;

    // 6. Reset dominance: preload out_a8 with 0x5C, then reset with write+read.
    ren_a8 = 1; raddr_a8 = 4'd3;
    tick();
    chk("preload_a8", {24'h0, out_a8}, 32'h5C);
    rst = 1; wen8 = 1; wmask8 = 1'b1; waddr8 = 4'd7; in8 = 8'h0A; raddr_a8 = 4'd7;
    tick();
    chk("rst_dominates_a", {24'h0, out_a8}, 32'h0);
    rst = 0; wen8 = 0;
    tick();
    chk("rst_write_lost", {24'h0, out_a8}, 32'h0);
    raddr_a8 = 4'd3;
    tick();
    chk("rst_cleared_mem", {24'h0, out_a8}, 32'h0);
    ren_a32 = 1; raddr_a32 = 4'd2;
    tick();
    chk("rst_cleared_mem32", out_a32, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
